// File: rtl/affine_filt_ctrl_11_if.sv
// affine_filt_ctrl_11_if: sample-in and filtered-out valid/ready streams
interface affine_filt_ctrl_11_if #(parameter int SUM_W = 17);
  logic in_valid;
  logic in_ready;
  logic signed [10:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [SUM_W-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/affine_filt_ctrl_11.sv
// affine_filt_ctrl_11: row sequencer feeding a 6-tap window to the MCM filter bank
module affine_filt_ctrl_11 #(
  parameter int BLK_W = 16,
  parameter int SUM_W = 17,
  parameter int ROW_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              frac_in,
  input  logic [ROW_W-1:0]        rows_in,
  affine_filt_ctrl_11_if.slave    s,
  output logic signed [10:0]      win0,
  output logic signed [10:0]      win1,
  output logic signed [10:0]      win2,
  output logic signed [10:0]      win3,
  output logic signed [10:0]      win4,
  output logic signed [10:0]      win5,
  output logic [3:0]              frac_sel,
  input  logic signed [SUM_W-1:0] filt_sum,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  localparam int CW = $clog2(BLK_W + 5);
  typedef enum logic [1:0] {IDLE, FILL, RUN, LAST} state_t;
  state_t state_q, state_d;
  logic signed [10:0] win_q [6];
  logic signed [10:0] win_d [6];
  logic [3:0] frac_q, frac_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ov_q, ov_d, done_q, done_d, err_q, err_d;
  logic acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '{default: '0};
      frac_q  <= '0;
      rows_q  <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      frac_q  <= frac_d;
      rows_q  <= rows_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // cnt_q counts accepted samples of the current row: 5 fill samples, then BLK_W output columns
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    frac_d  = frac_q;
    rows_d  = rows_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (acc) begin
      for (int i = 0; i < 5; i++) win_d[i] = win_q[i+1];
      win_d[5] = s.in_data;
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        if (frac_in == 0 || rows_in == 0) err_d = 1'b1;
        else begin
          frac_d  = frac_in;
          rows_d  = rows_in;
          cnt_d   = '0;
          win_d   = '{default: '0};
          state_d = FILL;
        end
      end
      FILL: if (acc && cnt_q == CW'(4)) state_d = RUN;
      RUN: begin
        ov_d = acc ? 1'b1 : (s.out_ready ? 1'b0 : ov_q);
        if (acc && cnt_q == CW'(BLK_W + 4)) state_d = LAST;
      end
      LAST: if (ov_q && s.out_ready) begin
        ov_d = 1'b0;
        if (rows_q != 1) begin
          rows_d  = rows_q - 1'b1;
          cnt_d   = '0;
          win_d   = '{default: '0};
          state_d = FILL;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s.in_ready  = state_q == FILL ? 1'b1 : state_q == RUN ? (!ov_q || s.out_ready) : 1'b0;
    acc         = s.in_valid && s.in_ready;
    s.out_valid = ov_q;
    s.out_data  = filt_sum;
    busy        = state_q != IDLE;
    done        = done_q;
    err         = err_q;
    frac_sel    = frac_q;
    win0        = win_q[0];
    win1        = win_q[1];
    win2        = win_q[2];
    win3        = win_q[3];
    win4        = win_q[4];
    win5        = win_q[5];
  end
endmodule

// File: tb/tb_affine_filt_ctrl_11.sv
// tb_affine_filt_ctrl_11: randomized stream bench with a window-sum reference model
module tb_affine_filt_ctrl_11;
  localparam int BLK = 4;
  localparam int SW = 17;
  localparam int RW = 6;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [3:0] frac_in = 0;
  logic [RW-1:0] rows_in = 0;
  logic signed [10:0] win0, win1, win2, win3, win4, win5;
  logic [3:0] frac_sel;
  logic signed [SW-1:0] filt_sum;
  logic busy, done, err;
  int checks = 0;
  int passed = 0;
  affine_filt_ctrl_11_if #(.SUM_W(SW)) bus ();
  affine_filt_ctrl_11 #(.BLK_W(BLK), .SUM_W(SW), .ROW_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .frac_in(frac_in), .rows_in(rows_in), .s(bus),
    .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4), .win5(win5),
    .frac_sel(frac_sel), .filt_sum(filt_sum), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic int dp(int a0, int a1, int a2, int a3, int a4, int a5, int f);
    return a0 + 2*a1 - 3*a2 + 4*a3 - 5*a4 + 6*a5 + 7*f;
  endfunction
  // stand-in for the MCM filter bank
  always_comb filt_sum = SW'(dp(win0, win1, win2, win3, win4, win5, int'(frac_sel)));
  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic run_block(int f, int r, int vm, int rm);
    int smp[$];
    int expq[$];
    int e5[$];
    int n, idx, oi, cyc, pd;
    bit got_done, stall, clr;
    n = r * (BLK + 5);
    for (int i = 0; i < n; i++) smp.push_back(int'($urandom_range(0, 2047)) - 1024);
    for (int row = 0; row < r; row++)
      for (int c = 0; c < BLK; c++) begin
        int b;
        b = row * (BLK + 5) + c;
        expq.push_back(dp(smp[b], smp[b+1], smp[b+2], smp[b+3], smp[b+4], smp[b+5], f));
        e5.push_back(smp[b+5]);
      end
    @(negedge clk);
    start = 1; frac_in = 4'(f); rows_in = RW'(r);
    @(negedge clk);
    start = 0;
    chk("start_w0", win0, 0);
    chk("start_w5", win5, 0);
    chk("start_busy", busy, 1);
    chk("start_frac", frac_sel, f);
    idx = 0; oi = 0; cyc = 0; pd = 0; got_done = 0; stall = 0; clr = 0;
    while (cyc < 2000) begin
      cyc++;
      if (done) begin
        got_done = 1;
        chk("done_outs", oi, expq.size());
        chk("done_busy", busy, 0);
        if (vm == 0 && rm == 0) chk("cycles", cyc, r * (BLK + 6) + 1);
        break;
      end
      if (clr) begin
        chk("row_clr_w0", win0, 0);
        chk("row_clr_w5", win5, 0);
        clr = 0;
      end
      if (stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, pd);
        stall = 0;
      end
      bus.in_valid = (idx < n) && (vm == 0 ? 1'b1 : vm == 2 ? cyc[0] : 1'($urandom_range(0, 1)));
      bus.in_data = idx < n ? 11'(smp[idx]) : '0;
      bus.out_ready = rm == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
      start = cyc == 3;
      frac_in = 4'(f ^ 5);
      rows_in = RW'($urandom_range(0, 3));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (oi < expq.size()) begin
          chk("data", bus.out_data, expq[oi]);
          chk("win5", win5, e5[oi]);
          chk("frac", frac_sel, f);
          if (oi % BLK == BLK - 1 && oi != expq.size() - 1) clr = 1;
        end else chk("extra_out", oi, expq.size() - 1);
        oi++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        chk("bp_in_ready", bus.in_ready, 0);
        stall = 1;
        pd = int'(bus.out_data);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(negedge clk);
    end
    start = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    if (!got_done) chk("timeout", cyc, -1);
    chk("in_count", idx, n);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  task automatic reject(int f, int r, int prev);
    @(negedge clk);
    start = 1; frac_in = 4'(f); rows_in = RW'(r);
    @(negedge clk);
    start = 0;
    chk("err", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_frac", frac_sel, prev);
    @(negedge clk);
    chk("err_pulse", err, 0);
  endtask
  task automatic mid_reset();
    @(negedge clk);
    start = 1; frac_in = 3; rows_in = 2;
    @(negedge clk);
    start = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1;
      bus.in_data = 11'(100 + i);
      @(negedge clk);
    end
    bus.in_valid = 0;
    chk("pre_rst_valid", bus.out_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_w0", win0, 0);
    chk("rst_w5", win5, 0);
    chk("rst_frac", frac_sel, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    chk("rst_done2", done, 0);
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_valid", bus.out_valid, 0);
    chk("init_in_ready", bus.in_ready, 0);
    chk("init_w0", win0, 0);
    chk("init_frac", frac_sel, 0);
    chk("init_err", err, 0);
    rst = 0;
    run_block(5, 1, 0, 0);
    run_block(5, 1, 0, 1);
    run_block(9, 2, 0, 0);
    run_block(5, 1, 2, 0);
    reject(0, 1, 5);
    reject(4, 0, 5);
    for (int k = 0; k < 4; k++) run_block(int'($urandom_range(1, 15)), int'($urandom_range(1, 3)), 1, 1);
    mid_reset();
    run_block(15, 3, 0, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/affine_filt_ctrl_11.md
Name: affine_filt_ctrl_11

Overview:
Row sequencer for the 6-tap affine interpolation datapath at 1/16 precision with 11-bit samples. It streams samples into a 6-entry sliding window and drives that window, plus a latched fractional-position select, into the per-tap MCM filter bank. It forwards the bank's combinational sum as a valid/ready output stream and counts columns and rows for one block. It sits between the reference-sample fetch stage and the next interpolation pass.

Parameters:
BLK_W, 16, output samples per row (valid range 1..64)
SUM_W, 17, width of the datapath sum input and of the output data
ROW_W, 6, width of the row-count input

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle block start; sampled only in IDLE
frac_in  in  4  fractional position 1..15; latched on start
rows_in  in  ROW_W  number of rows in the block; latched on start
in_valid  in  1  sample available
in_ready  out  1  sample accepted when in_valid&in_ready
in_data  in  11  signed reference sample
win0..win5  out  11 each  signed window to MCM taps t0..t5; win0 oldest, win5 newest
frac_sel  out  4  latched frac, selects Y<frac> in every tap
filt_sum  in  SUM_W  signed combinational sum from the datapath, a function of win0..win5 and frac_sel
out_valid  out  1  filtered sample valid
out_ready  in  1  downstream accepts
out_data  out  SUM_W  equals filt_sum, passed through
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last output handshake of the block
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset, synchronous: on the next edge, state=IDLE, all window registers=0, frac_sel=0, counters=0, out_valid=0, in_ready=0, busy=0, done=0, err=0. Reset mid-block abandons the block with no done pulse.
- States: IDLE, FILL, RUN, LAST.
- IDLE: in_ready=0.
  - start with frac_in==0 or rows_in==0: err=1 for one cycle, stay IDLE.
  - Otherwise: latch frac_sel and the row count, clear the window and col counter, go to FILL.
  - start is ignored in every other state.
- FILL: in_ready=1, out_valid=0.
  - Each accepted sample shifts the window: win0<=win1 ... win4<=win5, win5<=in_data.
  - After the 5th accepted sample of the row, go to RUN.
- RUN: in_ready = !out_valid | out_ready.
  - An accepted sample shifts the window and sets out_valid=1 on the next cycle. out_data=filt_sum is therefore computed from the full 6-sample window.
  - If out_valid and no input is accepted on an out handshake, out_valid clears.
  - While out_valid=1 and out_ready=0, the window, out_valid and out_data hold stable.
  - The col counter increments per accepted sample. On the accept of column BLK_W-1, go to LAST.
- LAST: in_ready=0. Wait for the out_valid&out_ready handshake of the final column, then:
  - If rows remain: decrement rows, clear the window and col counter, go to FILL.
  - Else: done=1 for one cycle, go to IDLE. busy falls in the same cycle done rises.
- Input traffic per row: BLK_W+5 samples. There is no overlap between rows, because the window is refilled for every row.
- Throughput: with out_ready held at 1 and in_valid held at 1, RUN sustains 1 output per cycle. Per row, the extra cycles are 5 (FILL) + 1 (LAST).
- Latency: 1 cycle from the accepting edge to out_valid. No arithmetic is done in this block; filt_sum widths and signs are the datapath's.
- frac_sel is constant for the whole block and is updated only on an accepted start.

Test Plan:
- Reset: drive rst=1 mid-RUN for 1 cycle -> next cycle state IDLE, win0..win5=0, out_valid=0, busy=0, no done pulse.
- Single row, BLK_W=4, frac_in=5, rows_in=1, samples 1..9, out_ready=1, in_valid=1 -> first out_valid has window {1,2,3,4,5,6}. Outputs follow on consecutive cycles with windows ending 6,7,8,9. frac_sel=5 throughout. done pulses 1 cycle after the 4th handshake.
- Backpressure: same as above with out_ready=0 for 3 cycles after the first out_valid -> in_ready=0, and window and out_data hold {1..6}. Resume -> no sample lost or duplicated.
- Multi-row: BLK_W=4, rows_in=2, 18 samples -> 8 outputs. Row 2's first window equals samples 10..15, and the window is cleared between rows.
- Rejects: start with frac_in=0 -> err pulse, stays IDLE. start with rows_in=0 -> err. start while busy -> ignored, frac_sel unchanged.
- Gapped input: in_valid toggles every other cycle during FILL and RUN -> the same output sequence as the single-row test, only spaced out.
